output_deskew_buffer: RTL and testbench
=======================================

OUTPUT_DESKEW_BUFFER -- requirements
Module: output_deskew_buffer

Interface
REQ-001 SHALL have parameter N, default 4, meaning the array dimension (number of columns and rows per tile).
REQ-002 SHALL have parameter ACC_WIDTH, default 32, meaning the result width per column.
REQ-003 SHALL have parameter DEPTH, default 8, meaning FIFO depth in aligned rows; it is a power of 2 and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: column-0 result valid this cycle.
REQ-007 SHALL have port skewed_input, input, N*ACC_WIDTH bits: column i at bits [i*ACC_WIDTH +: ACC_WIDTH]; column i data arrives i cycles after the in_valid that tags it.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the head row.
REQ-009 SHALL have port clear_overflow, input, 1 bit: synchronous clear of the overflow flag.
REQ-010 SHALL have port out_valid, output, 1 bit: FIFO non-empty.
REQ-011 SHALL have port out_data, output, N*ACC_WIDTH bits: aligned head row, with column i at [i*ACC_WIDTH +: ACC_WIDTH].
REQ-012 SHALL have port out_last, output, 1 bit: the head row is row N-1 of a tile.
REQ-013 SHALL have port level, output, $clog2(DEPTH+1) bits: current FIFO occupancy.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag indicating a row was dropped.

Function
REQ-015 SHALL delay column i by N-1-i register stages; column N-1 is not delayed.
REQ-016 SHALL delay in_valid by N-1 register stages to form an aligned write strobe.
REQ-017 SHALL write the aligned row into the FIFO on the edge where the aligned write strobe is high; in_valid high in cycle t yields out_valid high from cycle t+N when the FIFO was empty (latency N).
REQ-018 SHALL run the delay stages every cycle, independent of FIFO state; back-to-back in_valid sustains one row per cycle.
REQ-019 SHALL present the FIFO head as show-ahead: out_data and out_last are valid whenever out_valid is high, and hold stable until a pop.
REQ-020 SHALL pop on an edge where out_valid and out_ready are both high.
REQ-021 SHALL leave out_data unspecified while out_valid is low, but never X after reset.
REQ-022 SHALL maintain a write row counter, 0..N-1, that increments on each accepted write and wraps to 0 after N-1; a row written with counter N-1 is stored with last=1.
REQ-023 SHALL, on a simultaneous write and pop: perform both and leave level unchanged; this is legal when full.
REQ-024 SHALL, on a write when full and no pop: drop the row, set overflow, and leave the row counter and level unchanged.
REQ-025 SHALL treat a pop when empty as a no-op.
REQ-026 SHALL clear overflow on clear_overflow; if a drop occurs in the same cycle, overflow remains set.
REQ-027 SHALL wrap the read and write pointers modulo DEPTH; level ranges 0..DEPTH.

Reset
REQ-028 SHALL, while reset is high, asynchronously clear all delay stages, the strobe pipeline, pointers, row counter, level and overflow; out_valid=0, out_last=0, out_data=0.
REQ-029 SHALL discard rows in flight in the delay pipeline when reset is asserted mid-operation; no partial row is written after reset deasserts.
REQ-030 SHALL begin accepting in_valid on the first rising edge after reset deasserts.

Verification
REQ-031 SHALL cover single row (N=4): in_valid at cycle 0 with col0=0x11, then col1=0x22 at cycle 1, col2=0x33 at cycle 2, col3=0x44 at cycle 3 -> out_valid rises at cycle 4 with out_data={0x44,0x33,0x22,0x11}, level=1.
REQ-032 SHALL cover a full tile: 4 skewed rows back-to-back with out_ready=1 -> 4 consecutive aligned rows in order, with out_last high only on the 4th.
REQ-033 SHALL cover overflow (DEPTH=8): 9 rows with out_ready=0 -> level=8, overflow=1, and rows 1-8 drain intact; the 9th row is absent.
REQ-034 SHALL cover full plus simultaneous push/pop: level=8 with out_ready=1 and a write -> level stays 8, overflow stays 0.
REQ-035 SHALL cover reset mid-flight: reset asserted at cycle 2 after in_valid at cycle 0 -> out_valid never rises and level=0.
REQ-036 SHALL cover clear_overflow: pulse after an overflow -> overflow=0 next cycle; with a concurrent drop, overflow remains 1.

Source files
------------

// File: rtl/output_deskew_buffer.sv
// output_deskew_buffer
//   Realigns the skewed column results of an N-column systolic array into
//   whole rows. The rows are then buffered in a show-ahead FIFO DEPTH rows
//   deep. Column i of a result row arrives i cycles after the in_valid that
//   tags it. Column i is therefore delayed by N-1-i stages, so that every
//   column of a row lines up with the delayed write strobe.
//
// Ports
//   clk            : rising-edge clock
//   reset          : asynchronous active-high reset
//   in_valid       : column-0 result valid this cycle
//   skewed_input   : N columns of ACC_WIDTH bits; column i at [i*ACC_WIDTH +: ACC_WIDTH]
//   out_ready      : consumer accepts the head row
//   clear_overflow : synchronous clear of the sticky overflow flag
//   out_valid      : FIFO holds at least one row
//   out_data       : aligned head row (zero while empty)
//   out_last       : head row is the last row (row N-1) of a tile
//   level          : FIFO occupancy, 0..DEPTH
//   overflow       : sticky, set when a row was dropped because the FIFO was full
module output_deskew_buffer #(
  parameter int N         = 4,
  parameter int ACC_WIDTH = 32,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [N*ACC_WIDTH-1:0]       skewed_input,
  input  logic                         out_ready,
  input  logic                         clear_overflow,
  output logic                         out_valid,
  output logic [N*ACC_WIDTH-1:0]       out_data,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);

  localparam int W  = N * ACC_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] alignedRow;
  logic         wrStb;

  // Per-column delay lines. The last column arrives already aligned and
  // passes straight through.
  for (genvar i = 0; i < N; i++) begin : g_col
    if (i < N - 1) begin : g_dly
      localparam int D = N - 1 - i;
      logic [ACC_WIDTH-1:0] colDly_q [D];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < D; k++) colDly_q[k] <= '0;
        end else begin
          colDly_q[0] <= skewed_input[i*ACC_WIDTH +: ACC_WIDTH];
          for (int k = 1; k < D; k++) colDly_q[k] <= colDly_q[k-1];
        end
      end

      assign alignedRow[i*ACC_WIDTH +: ACC_WIDTH] = colDly_q[D-1];
    end else begin : g_pass
      assign alignedRow[i*ACC_WIDTH +: ACC_WIDTH] = skewed_input[i*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  // The write strobe follows column 0 through the same N-1 stages. Clearing
  // it on reset discards any row still in flight.
  if (N > 1) begin : g_stb
    logic [N-2:0] vld_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= in_valid;
        for (int k = 1; k < N - 1; k++) vld_q[k] <= vld_q[k-1];
      end
    end

    assign wrStb = vld_q[N-2];
  end else begin : g_nostb
    assign wrStb = in_valid;
  end

  // FIFO storage. It has no reset, because the head is gated to zero while
  // the FIFO is empty.
  logic [W-1:0]     fifoMem [DEPTH];
  logic [DEPTH-1:0] fifoLast;

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic [RW-1:0] row_q, row_d;
  logic          overflow_q, overflow_d;

  logic isEmpty, isFull, doPop, doWrite, doDrop, rowLast;

  // Push/pop arbitration. A pop frees the slot this cycle, so a write is
  // still accepted when the FIFO is full.
  always_comb begin
    isEmpty = (level_q == '0);
    isFull  = (level_q == LW'(DEPTH));
    doPop   = !isEmpty && out_ready;
    doWrite = wrStb && (!isFull || doPop);
    doDrop  = wrStb && isFull && !doPop;
    rowLast = (row_q == RW'(N - 1));

    wrPtr_d    = doWrite ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d    = doPop   ? rdPtr_q + PW'(1) : rdPtr_q;
    row_d      = row_q;
    if (doWrite) row_d = rowLast ? '0 : row_q + RW'(1);

    level_d = level_q;
    if (doWrite && !doPop) level_d = level_q + LW'(1);
    if (!doWrite && doPop) level_d = level_q - LW'(1);

    // A drop in the same cycle outranks a clear request.
    overflow_d = overflow_q;
    if (doDrop) overflow_d = 1'b1;
    else if (clear_overflow) overflow_d = 1'b0;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      row_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      row_q      <= row_d;
      overflow_q <= overflow_d;
    end
  end

  // Row storage. When the FIFO is full and a pop happens at the same time,
  // the write lands in the slot that is being vacated.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      fifoMem[wrPtr_q]  <= alignedRow;
      fifoLast[wrPtr_q] <= rowLast;
    end
  end

  assign out_valid = !isEmpty;
  assign out_data  = isEmpty ? '0 : fifoMem[rdPtr_q];
  assign out_last  = !isEmpty && fifoLast[rdPtr_q];
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_output_deskew_buffer.sv
// tb_output_deskew_buffer
//   Drives output_deskew_buffer with directed and random rows. Every cycle
//   the outputs are compared against a row-level model. The model is an
//   ideal queue of complete rows, where a row launched in cycle t lands in
//   the queue at the end of cycle t+N-1.
module tb_output_deskew_buffer;

  localparam int N     = 4;
  localparam int ACC   = 32;
  localparam int DEPTH = 8;
  localparam int W     = N * ACC;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  skewed_input;
  logic          out_ready;
  logic          clear_overflow;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [LW-1:0] level;
  logic          overflow;

  output_deskew_buffer #(.N(N), .ACC_WIDTH(ACC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .skewed_input   (skewed_input),
    .out_ready      (out_ready),
    .clear_overflow (clear_overflow),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .level          (level),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } rowT;

  rowT          modelQ[$];
  int           modelRow;
  logic         modelOvf;
  logic         histValid [16];
  logic [W-1:0] histData [16];
  int           cyc;
  int           checks;
  int           errors;

  task automatic checkVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The model's view of the outputs between clock edges.
  task automatic checkOutput();
    checkVal("out_valid", W'(out_valid), W'(modelQ.size() != 0));
    checkVal("level", W'(level), W'(modelQ.size()));
    checkVal("overflow", W'(overflow), W'(modelOvf));
    if (modelQ.size() != 0) begin
      checkVal("out_data", out_data, modelQ[0].data);
      checkVal("out_last", W'(out_last), W'(modelQ[0].last));
    end else begin
      checkVal("data_known", W'($isunknown(out_data)), W'(0));
    end
  endtask

  function automatic logic [W-1:0] randRow();
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*ACC +: ACC] = $urandom;
    return r;
  endfunction

  // One clock cycle. Column i carries the row launched i cycles ago;
  // otherwise it carries junk. At the edge the model pops, then writes or drops.
  task automatic applyStimulus(input logic iv, input logic [W-1:0] row,
                               input logic rdy, input logic clr);
    logic [W-1:0] sk;
    int           idx;
    int           wIdx;
    logic         wr;
    logic         pop;
    logic         drop;
    histValid[cyc % 16] = iv;
    histData[cyc % 16]  = row;
    for (int i = 0; i < N; i++) begin
      idx = (cyc - i) % 16;
      sk[i*ACC +: ACC] = histValid[idx] ? histData[idx][i*ACC +: ACC] : ACC'($urandom);
    end
    in_valid       = iv;
    skewed_input   = sk;
    out_ready      = rdy;
    clear_overflow = clr;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    wIdx = (cyc - (N - 1)) % 16;
    wr   = histValid[wIdx];
    pop  = (modelQ.size() != 0) && rdy;
    drop = wr && (modelQ.size() == DEPTH) && !pop;
    if (pop) void'(modelQ.pop_front());
    if (wr && !drop) begin
      modelQ.push_back('{data: histData[wIdx], last: (modelRow == N - 1)});
      modelRow = (modelRow + 1) % N;
    end
    if (drop) modelOvf = 1'b1;
    else if (clr) modelOvf = 1'b0;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, randRow(), rdy, 1'b0);
  endtask

  // Asserts reset for n edges and empties the model, including rows in flight.
  task automatic doReset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    checkVal("rst_out_valid", W'(out_valid), W'(0));
    checkVal("rst_out_data", out_data, W'(0));
    checkVal("rst_out_last", W'(out_last), W'(0));
    checkVal("rst_level", W'(level), W'(0));
    checkVal("rst_overflow", W'(overflow), W'(0));
    repeat (n) @(posedge clk);
    modelQ.delete();
    modelRow = 0;
    modelOvf = 1'b0;
    for (int k = 0; k < 16; k++) histValid[k] = 1'b0;
    cyc += n;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] r;
    logic [W-1:0] row31;
    checks = 0;
    errors = 0;
    cyc    = 16;
    reset  = 1'b1;
    in_valid = 1'b0;
    skewed_input = '0;
    out_ready = 1'b0;
    clear_overflow = 1'b0;
    modelQ.delete();
    modelRow = 0;
    modelOvf = 1'b0;
    for (int k = 0; k < 16; k++) histValid[k] = 1'b0;
    @(posedge clk);
    doReset(3);

    // A single row becomes visible N cycles after its in_valid.
    $display("[TB] single row");
    row31 = {32'h44, 32'h33, 32'h22, 32'h11};
    applyStimulus(1'b1, row31, 1'b0, 1'b0);
    idle(3, 1'b0);
    checkVal("single_valid", W'(out_valid), W'(1));
    checkVal("single_data", out_data, {32'h44, 32'h33, 32'h22, 32'h11});
    checkVal("single_level", W'(level), W'(1));
    idle(2, 1'b1);

    // Full tile back-to-back with the consumer always ready. The row counter
    // was advanced by the single row above, so realign the tile with 3 more rows.
    $display("[TB] full tile");
    for (int k = 0; k < 3 + N; k++) applyStimulus(1'b1, randRow(), 1'b1, 1'b0);
    idle(N + 1, 1'b1);

    // Overflow: nine rows, no consumer.
    $display("[TB] overflow");
    for (int k = 0; k < DEPTH + 1; k++) applyStimulus(1'b1, randRow(), 1'b0, 1'b0);
    idle(N, 1'b0);
    checkVal("ovf_level", W'(level), W'(DEPTH));
    checkVal("ovf_flag", W'(overflow), W'(1));
    idle(DEPTH + 1, 1'b1);
    applyStimulus(1'b0, randRow(), 1'b0, 1'b1);
    checkVal("clr_flag", W'(overflow), W'(0));

    // Refill to full, then push and pop in the same cycles while full.
    $display("[TB] full push/pop");
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, randRow(), 1'b0, 1'b0);
    idle(N - 1, 1'b0);
    checkVal("full_level", W'(level), W'(DEPTH));
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, randRow(), (k == N - 1), 1'b0);
    applyStimulus(1'b0, randRow(), 1'b1, 1'b0);
    applyStimulus(1'b0, randRow(), 1'b1, 1'b0);
    applyStimulus(1'b0, randRow(), 1'b1, 1'b0);
    checkVal("pp_level", W'(level), W'(DEPTH));
    checkVal("pp_ovf", W'(overflow), W'(0));

    // A drop in the same cycle as a clear leaves the flag set.
    $display("[TB] clear with concurrent drop");
    applyStimulus(1'b1, randRow(), 1'b0, 1'b0);
    idle(N - 2, 1'b0);
    applyStimulus(1'b0, randRow(), 1'b0, 1'b1);
    checkVal("clrdrop_flag", W'(overflow), W'(1));
    applyStimulus(1'b0, randRow(), 1'b0, 1'b1);
    checkVal("clr2_flag", W'(overflow), W'(0));
    idle(DEPTH + 1, 1'b1);

    // Reset while a row is still in the delay pipeline.
    $display("[TB] reset mid-flight");
    applyStimulus(1'b1, randRow(), 1'b1, 1'b0);
    applyStimulus(1'b0, randRow(), 1'b1, 1'b0);
    doReset(1);
    idle(6, 1'b1);
    checkVal("midrst_level", W'(level), W'(0));
    checkVal("midrst_valid", W'(out_valid), W'(0));

    // Random traffic, with one reset partway through.
    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      if (k == 200) doReset(1);
      r = randRow();
      applyStimulus($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0);
    end
    idle(DEPTH + N + 2, 1'b1);
    checkVal("end_level", W'(level), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
